// File: rtl/apb_cfg_pkg.sv
// Shared definitions for the APB configuration master: FSM encoding, default bus widths
// and the timer register map used by sequencers and benches.
package apb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    localparam logic [15:0] TIM_CR1   = 16'h0000;
    localparam logic [15:0] TIM_SMCR  = 16'h0008;
    localparam logic [15:0] TIM_EGR   = 16'h0014;
    localparam logic [15:0] TIM_CCMR1 = 16'h0018;
    localparam logic [15:0] TIM_CCER  = 16'h0020;
    localparam logic [15:0] TIM_ARR   = 16'h002C;
    localparam logic [15:0] TIM_CCR1  = 16'h0034;
    localparam logic [15:0] TIM_BDTR  = 16'h0044;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/apb_tmo_cnt.sv
// ACCESS-phase wait counter. Expiry is flagged combinationally on the wait cycle that
// would bring the count to TIMEOUT; TIMEOUT=0 disables expiry entirely.
module apb_tmo_cnt #(
    parameter int TIMEOUT = 256,
    parameter int TMO_W   = 9
) (
    input  logic apb_clk,
    input  logic apb_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge apb_clk) begin
        if (apb_rst || clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_cfg_master.sv
// APB3 initiator: one valid/ready command in, one APB transfer out, one response back
// carrying read data, slave error and timeout status.
module apb_cfg_master
    import apb_cfg_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 256,
    parameter int TMO_W   = 9
) (
    input  logic              apb_clk,
    input  logic              apb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_tmo,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic [DATA_W-1:0] apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr,
    output logic              busy
);

    apb_state_t state;
    logic       tmo_expired;

    apb_tmo_cnt #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_tmo_cnt (
        .apb_clk (apb_clk),
        .apb_rst (apb_rst),
        .clear   (state != ACCESS),
        .enable  ((state == ACCESS) && !apb_pready),
        .expired (tmo_expired)
    );

    // Accepting is gated by reset so a command offered during reset is never lost silently.
    assign cmd_ready = (state == IDLE) && !apb_rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            state       <= IDLE;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_tmo     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        apb_paddr  <= cmd_addr;
                        apb_pwdata <= cmd_wdata;
                        apb_pwrite <= cmd_write;
                        if (is_word_aligned(cmd_addr[1:0])) begin
                            state    <= SETUP;
                            apb_psel <= 1'b1;
                        end else begin
                            // Misaligned: answer with an error without touching the bus.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_tmo   <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb_penable <= 1'b1;
                end
                ACCESS: begin
                    // pready takes priority over a timeout expiring in the same cycle.
                    if (apb_pready) begin
                        state       <= RESP;
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                        rsp_err     <= apb_pslverr;
                        rsp_tmo     <= 1'b0;
                    end else if (tmo_expired) begin
                        state       <= RESP;
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_tmo     <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench: randomized commands against a timeline-level reference model,
// with an APB slave holding a small register file and configurable wait/error behaviour.
module tb_apb_cfg_master;
    import apb_cfg_pkg::*;

    localparam int TMO = 16;

    logic        apb_clk = 1'b0;
    logic        apb_rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_tmo;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [15:0] apb_paddr;
    logic [31:0] apb_pwdata, apb_prdata;
    logic        apb_pready, apb_pslverr;
    logic        busy;

    // Slave behaviour for the transfer in flight, set by the driver before each command.
    int          cfg_wait;
    bit          cfg_err, cfg_stuck;
    logic [31:0] slv_mem [64];
    logic [31:0] ref_mem [64];
    logic [15:0] offs [8];

    int n_checks = 0;
    int n_errors = 0;

    always #5 apb_clk = ~apb_clk;

    apb_cfg_master #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .TIMEOUT (TMO),
        .TMO_W   (9)
    ) dut (
        .apb_clk     (apb_clk),
        .apb_rst     (apb_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_tmo     (rsp_tmo),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APB slave: completes on the (cfg_wait+1)-th ACCESS cycle unless stuck; junk elsewhere.
    initial begin : slave
        int acc;
        acc = 0;
        apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = '0;
        forever begin
            @(posedge apb_clk); #1;
            if (apb_psel && apb_penable) begin
                if (!cfg_stuck && acc == cfg_wait) begin
                    apb_pready  = 1'b1;
                    apb_pslverr = cfg_err;
                    apb_prdata  = (!apb_pwrite && !cfg_err) ? slv_mem[apb_paddr[7:2]] : 32'h0;
                    if (apb_pwrite && !cfg_err) slv_mem[apb_paddr[7:2]] = apb_pwdata;
                    acc = 0;
                end else begin
                    apb_pready  = 1'b0;
                    apb_pslverr = 1'($urandom);
                    apb_prdata  = $urandom;
                    acc++;
                end
            end else begin
                apb_pready  = 1'($urandom);
                apb_pslverr = 1'($urandom);
                apb_prdata  = $urandom;
                acc = 0;
            end
        end
    end

    // Reference model: each command is a timeline of k cycles since acceptance
    // (1 SETUP cycle, n ACCESS cycles, then response until consumed).
    initial begin : compare
        bit          live, busy_m, rst_pend, mis, tmo_c;
        int          k, n;
        logic [15:0] m_addr;
        logic [31:0] m_wdata, e_rdata;
        logic        m_write, e_err, e_tmo;
        bit          e_setup, e_access, e_resp;
        live = 0; busy_m = 0; rst_pend = 0; mis = 0; k = 0; n = 0;
        m_addr = '0; m_wdata = '0; m_write = 1'b0;
        e_rdata = '0; e_err = 1'b0; e_tmo = 1'b0;
        forever begin
            @(negedge apb_clk);
            e_setup  = busy_m && !mis && k == 0;
            e_access = busy_m && !mis && k >= 1 && k <= n;
            e_resp   = busy_m && (mis || k > n);
            if (rst_pend) begin
                check("rst_psel", apb_psel, 0);
                check("rst_penable", apb_penable, 0);
                check("rst_pwrite", apb_pwrite, 0);
                check("rst_paddr", apb_paddr, 0);
                check("rst_pwdata", apb_pwdata, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_rdata", rsp_rdata, 0);
                check("rst_rsp_err", rsp_err, 0);
                check("rst_rsp_tmo", rsp_tmo, 0);
            end
            if (live) begin
                check("psel", apb_psel, e_setup || e_access);
                check("penable", apb_penable, e_access);
                check("rsp_valid", rsp_valid, e_resp);
                check("busy", busy, busy_m);
                check("cmd_ready", cmd_ready, !busy_m && !apb_rst);
                check("paddr", apb_paddr, m_addr);
                check("pwrite", apb_pwrite, m_write);
                check("pwdata", apb_pwdata, m_wdata);
                if (e_resp) begin
                    check("rsp_rdata", rsp_rdata, e_rdata);
                    check("rsp_err", rsp_err, e_err);
                    check("rsp_tmo", rsp_tmo, e_tmo);
                end
            end
            rst_pend = apb_rst;
            if (apb_rst) begin
                live = 1; busy_m = 0;
                m_addr = '0; m_wdata = '0; m_write = 1'b0;
            end else if (live) begin
                if (busy_m) begin
                    if (e_resp && rsp_ready) busy_m = 0;
                    else k++;
                end else if (cmd_valid) begin
                    busy_m  = 1; k = 0;
                    m_addr  = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata;
                    mis     = cmd_addr[1:0] != 2'b00;
                    tmo_c   = cfg_stuck || cfg_wait >= TMO;
                    n       = tmo_c ? TMO : cfg_wait + 1;
                    if (mis) begin
                        e_rdata = '0; e_err = 1'b1; e_tmo = 1'b0;
                    end else if (tmo_c) begin
                        e_rdata = '0; e_err = 1'b1; e_tmo = 1'b1;
                    end else begin
                        e_err   = cfg_err; e_tmo = 1'b0;
                        e_rdata = (cmd_write || cfg_err) ? 32'h0 : ref_mem[cmd_addr[7:2]];
                        if (cmd_write && !cfg_err) ref_mem[cmd_addr[7:2]] = cmd_wdata;
                    end
                end
            end
        end
    end

    // Issue one command and collect its response plus simple timing observations.
    task automatic do_cmd(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input int wait_n, input bit serr, input bit stuck, input int stall,
                          output logic [31:0] rdata, output logic err, output logic tmo,
                          output int lat, output int pen_cyc, output int psel_cyc);
        bit acc, done, seen;
        int guard, vcnt;
        cfg_wait = wait_n; cfg_err = serr; cfg_stuck = stuck;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = (stall == 0);
        rdata = '0; err = 1'b0; tmo = 1'b0; lat = 0; pen_cyc = 0; psel_cyc = 0;
        acc = 0; guard = 0;
        while (!acc) begin
            @(negedge apb_clk); acc = cmd_ready;
            @(posedge apb_clk); #1;
            guard++;
            if (!acc && guard > 50) begin
                check("accept_timeout", 0, 1);
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
        done = 0; seen = 0; guard = 0; vcnt = 0;
        while (!done) begin
            @(negedge apb_clk);
            if (!seen) lat++;
            if (apb_psel) psel_cyc++;
            if (apb_penable) pen_cyc++;
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; rdata = rsp_rdata; err = rsp_err; tmo = rsp_tmo;
                end
                vcnt++;
                done = rsp_ready;
            end
            @(posedge apb_clk); #1;
            if (!done) rsp_ready = (vcnt >= stall);
            guard++;
            if (!done && guard > 100) begin
                check("rsp_timeout", 0, 1);
                return;
            end
        end
    endtask

    // Start a read toward a hung slave and pull reset in the middle of ACCESS.
    task automatic do_abort(input logic [15:0] addr);
        bit acc;
        int guard, pen;
        cfg_wait = 0; cfg_err = 0; cfg_stuck = 1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = $urandom;
        acc = 0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge apb_clk); acc = cmd_ready;
            @(posedge apb_clk); #1;
            guard++;
        end
        cmd_valid = 1'b0;
        pen = 0; guard = 0;
        while (pen < 3 && guard < 40) begin
            @(negedge apb_clk); if (apb_penable) pen++;
            @(posedge apb_clk); #1;
            guard++;
        end
        check("abort_reached_access", pen, 3);
        apb_rst = 1'b1;
        repeat (2) begin @(posedge apb_clk); #1; end
        apb_rst = 1'b0;
        cfg_stuck = 0;
        @(negedge apb_clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_psel", apb_psel, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        @(posedge apb_clk); #1;
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        er, tm;
        int          lat, pen, psl;
        logic [15:0] addr;
        bit          wr, serr, stuck;
        int          w, stall;

        for (int i = 0; i < 64; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        offs = '{TIM_CR1, TIM_SMCR, TIM_EGR, TIM_CCMR1, TIM_CCER, TIM_ARR, TIM_CCR1, TIM_BDTR};
        cfg_wait = 0; cfg_err = 0; cfg_stuck = 0;
        apb_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) begin @(posedge apb_clk); #1; end
        apb_rst = 1'b0;

        // Zero-wait write to ARR, then read it back-to-back.
        do_cmd(1, TIM_ARR, 32'h0000_00FF, 0, 0, 0, 0, rd, er, tm, lat, pen, psl);
        check("t1_lat", lat, 3);
        check("t1_psel_cycles", psl, 2);
        check("t1_pen_cycles", pen, 1);
        check("t1_err", er, 0);
        check("t1_rdata", rd, 32'h0);
        do_cmd(0, TIM_ARR, 32'h0, 0, 0, 0, 0, rd, er, tm, lat, pen, psl);
        check("t1_arr_readback", rd, 32'h0000_00FF);

        // Read with three wait states.
        do_cmd(1, TIM_CCR1, 32'h0000_003F, 0, 0, 0, 0, rd, er, tm, lat, pen, psl);
        do_cmd(0, TIM_CCR1, 32'h0, 3, 0, 0, 0, rd, er, tm, lat, pen, psl);
        check("t2_pen_cycles", pen, 4);
        check("t2_lat", lat, 6);
        check("t2_rdata", rd, 32'h0000_003F);

        // Slave error, then a normal command.
        do_cmd(1, TIM_CCER, 32'h1234_5678, 1, 1, 0, 0, rd, er, tm, lat, pen, psl);
        check("t3_err", er, 1);
        check("t3_tmo", tm, 0);
        do_cmd(0, TIM_CCR1, 32'h0, 0, 0, 0, 1, rd, er, tm, lat, pen, psl);
        check("t3_next_err", er, 0);
        check("t3_next_rdata", rd, 32'h0000_003F);

        // Timeout, and pready on the last allowed cycle.
        do_cmd(0, TIM_BDTR, 32'h0, 0, 0, 1, 0, rd, er, tm, lat, pen, psl);
        check("t4_pen_cycles", pen, 16);
        check("t4_lat", lat, 18);
        check("t4_err", er, 1);
        check("t4_tmo", tm, 1);
        check("t4_rdata", rd, 32'h0);
        do_cmd(0, TIM_ARR, 32'h0, 15, 0, 0, 0, rd, er, tm, lat, pen, psl);
        check("t4_edge_pen_cycles", pen, 16);
        check("t4_edge_err", er, 0);
        check("t4_edge_tmo", tm, 0);
        check("t4_edge_rdata", rd, 32'h0000_00FF);

        // Misaligned address.
        do_cmd(1, 16'h0035, 32'hDEAD_BEEF, 0, 0, 0, 0, rd, er, tm, lat, pen, psl);
        check("t5_psel_cycles", psl, 0);
        check("t5_lat", lat, 1);
        check("t5_err", er, 1);
        check("t5_tmo", tm, 0);

        // Stalled response, then reset in the middle of the next transfer.
        do_cmd(0, TIM_ARR, 32'h0, 1, 0, 0, 5, rd, er, tm, lat, pen, psl);
        check("t6_rdata", rd, 32'h0000_00FF);
        do_abort(TIM_CR1);

        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) < 5) addr = offs[$urandom_range(0, 7)];
            else addr = {8'h00, 6'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            w     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            stuck = ($urandom_range(0, 19) == 0);
            serr  = ($urandom_range(0, 7) == 0);
            stall = $urandom_range(0, 3);
            do_cmd(wr, addr, $urandom, w, serr, stuck, stall, rd, er, tm, lat, pen, psl);
        end

        repeat (3) @(posedge apb_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
